// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Serial-to-parallel receiver for the transmitter's byte stream. Detects a
//   start bit, samples each bit at mid-bit, assembles DATA_W bits LSB- or
//   MSB-first and validates the stop bit (and optionally even parity).
//
// Parameters
//   DATA_W      data bits per frame
//   BIT_CYCLES  CLK cycles per serial bit (even, >= 4)
//
// Ports
//   CLK            system clock, rising edge
//   RST_N          synchronous active-low reset
//   serial_in      serial line, idle high
//   shift_dir      0 = LSB first, 1 = MSB first; captured at start detect
//   signal_output  last good received word
//   data_valid     one-cycle pulse when signal_output is updated
//   frame_error    one-cycle pulse on a bad stop bit
//   parity_error   one-cycle pulse on parity mismatch (0 when parity disabled)
//   busy           high in every state except IDLE
//
// Build option
//   SERIAL_FRAME_RECEIVER_PARITY_EN  adds an even-parity slot after the data.
module serial_frame_receiver #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              serial_in,
  input  logic              shift_dir,
  output logic [DATA_W-1:0] signal_output,
  output logic              data_valid,
  output logic              frame_error,
  output logic              parity_error,
  output logic              busy
);

  localparam int H  = BIT_CYCLES / 2;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int PW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t            state;
  logic              s1, s2;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     pos;
  logic              dir_q;
  logic [DATA_W-1:0] sh;
  logic              bit_end;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  logic              par_acc;   // running XOR of data bits plus parity bit
`endif

  // Counter reaching the last cycle of a bit slot; from the start midpoint
  // this lands every slot sample on the middle of the next bit.
  assign bit_end = (cnt == CW'(BIT_CYCLES - 1));

  // Destination bit of the current sample depends on the latched direction.
  always_comb begin
    pos = idx;
    if (dir_q) pos = PW'(DATA_W - 1) - idx;
  end

`ifndef SERIAL_FRAME_RECEIVER_PARITY_EN
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      dir_q         <= 1'b0;
      sh            <= '0;
      signal_output <= '0;
      data_valid    <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
      par_acc       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      s1          <= serial_in;
      s2          <= s1;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
      parity_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          dir_q <= shift_dir;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
          par_acc <= 1'b0;
`endif
          if (!s2) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CW'(H - 1)) begin
            cnt <= '0;
            idx <= '0;
            if (!s2) begin
              state <= DATA;
            end else begin
              // Glitch shorter than half a bit: drop silently.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            sh[pos] <= s2;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
            par_acc <= par_acc ^ s2;
`endif
            if (idx == PW'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            par_acc <= par_acc ^ s2;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (!s2) begin
              // Bad stop wins over parity; wait for the line to release.
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
              if (par_acc) begin
                parity_error <= 1'b1;
              end else begin
                signal_output <= sh;
                data_valid    <= 1'b1;
              end
`else
              signal_output <= sh;
              data_valid    <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low break must not look like a fresh start bit.
          if (s2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
`timescale 1ns/1ps
module tb_serial_frame_receiver;

  localparam int BC = 4;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       serial_in = 1'b1;
  logic       shift_dir = 1'b0;
  logic [7:0] signal_output;
  logic       data_valid, frame_error, parity_error, busy;

  int n_chk = 0, n_fail = 0;
  int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, base_dv, base_fe, base_pe;
  logic [7:0] cap_last = 8'h00, cap_prev = 8'h00;

  always #5 CLK = ~CLK;

  serial_frame_receiver #(.DATA_W(8), .BIT_CYCLES(BC)) dut (
    .CLK(CLK), .RST_N(RST_N), .serial_in(serial_in), .shift_dir(shift_dir),
    .signal_output(signal_output), .data_valid(data_valid),
    .frame_error(frame_error), .parity_error(parity_error), .busy(busy)
  );

  // Pulse monitor, sampled shortly after each rising edge.
  always @(posedge CLK) begin
    #2;
    if (data_valid) begin
      dv_cnt++;
      cap_prev = cap_last;
      cap_last = signal_output;
    end
    if (frame_error)  fe_cnt++;
    if (parity_error) pe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame LSB-first on the line. Returns at the falling edge just
  // before the edge that registers the result pulse.
  task automatic send(input logic [7:0] d, input logic stop, input logic bad_par,
                      input bit flip);
    serial_in = 1'b0;
    cyc(BC);
    if (flip) shift_dir = ~shift_dir;
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      cyc(BC);
    end
    if (PAR) begin
      serial_in = (^d) ^ bad_par;
      cyc(BC);
    end
    serial_in = stop;
    cyc(BC);
  endtask

  initial begin
    cyc(3);
    chk("rst_out", signal_output, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_fe", frame_error, 1'b0);
    chk("rst_pe", parity_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    RST_N = 1'b1;
    cyc(2);

    // LSB-first 0xA5, pulse registered at edge 40 (44 with parity)
    base_dv = dv_cnt;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a5_no_early_dv", dv_cnt, base_dv);
    chk("a5_busy_stop", busy, 1'b1);
    cyc(1);
    chk("a5_dv", data_valid, 1'b1);
    chk("a5_out", signal_output, 8'hA5);
    chk("a5_busy_done", busy, 1'b0);
    cyc(1);
    chk("a5_dv_one_cycle", data_valid, 1'b0);
    chk("a5_dv_count", dv_cnt, base_dv + 1);
    cyc(4);

    // 0xAA on the line, received MSB-first; mid-frame flip of shift_dir ignored
    shift_dir = 1'b1;
    base_dv = dv_cnt;
    send(8'hAA, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk("msb_dv", data_valid, 1'b1);
    chk("msb_out", signal_output, 8'h55);
    cyc(1);
    chk("msb_dv_count", dv_cnt, base_dv + 1);
    cyc(4);

    // One-cycle glitch: START at edge 2, back to IDLE at edge 4
    base_dv = dv_cnt; base_fe = fe_cnt; base_pe = pe_cnt;
    serial_in = 1'b0;
    cyc(1);
    serial_in = 1'b1;
    cyc(2);
    chk("glitch_busy_start", busy, 1'b1);
    cyc(2);
    chk("glitch_busy_idle", busy, 1'b0);
    cyc(8);
    chk("glitch_out", signal_output, 8'h55);
    chk("glitch_no_dv", dv_cnt, base_dv);
    chk("glitch_no_fe", fe_cnt, base_fe);
    chk("glitch_no_pe", pe_cnt, base_pe);

    // Bad stop bit, line held low (break), then a good frame
    shift_dir = 1'b0;
    base_dv = dv_cnt; base_fe = fe_cnt;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk("fe_pulse", frame_error, 1'b1);
    chk("fe_no_dv", data_valid, 1'b0);
    chk("fe_out_held", signal_output, 8'h55);
    cyc(1);
    chk("fe_one_cycle", frame_error, 1'b0);
    cyc(18);
    chk("fe_wait_high_busy", busy, 1'b1);
    chk("fe_count", fe_cnt, base_fe + 1);
    chk("fe_no_retrigger_dv", dv_cnt, base_dv);
    serial_in = 1'b1;
    cyc(4);
    chk("fe_release_idle", busy, 1'b0);
    send(8'h81, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk("after_fe_dv", data_valid, 1'b1);
    chk("after_fe_out", signal_output, 8'h81);
    cyc(4);

    // Reset during data bit 4, then a clean 0x7E
    base_dv = dv_cnt; base_fe = fe_cnt; base_pe = pe_cnt;
    serial_in = 1'b0;
    cyc(BC);
    for (int i = 0; i < 4; i++) begin
      serial_in = (i == 0) ? 1'b0 : 1'b1;
      cyc(BC);
    end
    serial_in = 1'b1;
    cyc(2);
    RST_N = 1'b0;
    cyc(1);
    RST_N = 1'b1;
    chk("midrst_out", signal_output, 8'h00);
    chk("midrst_dv", data_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_fe", frame_error, 1'b0);
    cyc(12);
    chk("midrst_no_dv", dv_cnt, base_dv);
    chk("midrst_no_fe", fe_cnt, base_fe);
    chk("midrst_no_pe", pe_cnt, base_pe);
    send(8'h7E, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk("after_rst_dv", data_valid, 1'b1);
    chk("after_rst_out", signal_output, 8'h7E);
    cyc(4);

    // Back-to-back frames with no idle gap
    base_dv = dv_cnt;
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk("b2b_dv", data_valid, 1'b1);
    chk("b2b_out", signal_output, 8'hC3);
    chk("b2b_first", cap_prev, 8'h5A);
    cyc(1);
    chk("b2b_count", dv_cnt, base_dv + 2);
    cyc(4);

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    // 0x0F has four ones: parity bit 1 is odd overall, 0 is even
    base_dv = dv_cnt;
    send(8'h0F, 1'b1, 1'b1, 1'b0);
    cyc(1);
    chk("par_err_pulse", parity_error, 1'b1);
    chk("par_err_no_dv", data_valid, 1'b0);
    chk("par_err_out_held", signal_output, 8'hC3);
    cyc(1);
    chk("par_err_one_cycle", parity_error, 1'b0);
    cyc(4);
    send(8'h0F, 1'b1, 1'b0, 1'b0);
    chk("par_ok_no_early", dv_cnt, base_dv);
    cyc(1);
    chk("par_ok_dv", data_valid, 1'b1);
    chk("par_ok_out", signal_output, 8'h0F);
    chk("par_ok_no_pe", parity_error, 1'b0);
    cyc(4);
`else
    chk("no_parity_pulses", pe_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
